// File: rtl/page_table_responder_pkg.sv
// Shared types, PTE layout and helpers for the page-table responder.
// The PTE helpers are also used by the TLB side.
package page_table_responder_pkg;

  localparam int VPN_W_DEF = 6;
  localparam int PPN_W_DEF = 2;

  localparam int PTE_V = 31;
  localparam int PTE_D = 30;
  localparam int PTE_R = 29;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    LOOKUP,
    EVICT,
    FILL,
    RESP
  } state_t;

  function automatic logic [31:0] pte_make(
    input logic        v,
    input logic        d,
    input logic        r,
    input logic [15:0] ppn
  );
    logic [31:0] p;
    p        = '0;
    p[15:0]  = ppn;
    p[PTE_V] = v;
    p[PTE_D] = d;
    p[PTE_R] = r;
    return p;
  endfunction

  function automatic logic pte_valid(input logic [31:0] p);
    return p[PTE_V];
  endfunction

  function automatic logic pte_dirty(input logic [31:0] p);
    return p[PTE_D];
  endfunction

  function automatic logic pte_ref(input logic [31:0] p);
    return p[PTE_R];
  endfunction

  function automatic logic [15:0] pte_ppn(input logic [31:0] p);
    return p[15:0];
  endfunction

endpackage

// File: rtl/page_table_responder_frame_allocator.sv
// Frame owner table plus clock hand; the hand frame is the next victim.
// claim records the new owner of the hand frame, advance steps the hand.
module page_table_responder_frame_allocator
  import page_table_responder_pkg::*;
#(
  parameter int VPN_W = VPN_W_DEF,
  parameter int PPN_W = PPN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             claim,
  input  logic [VPN_W-1:0] claim_vpn,
  input  logic             advance,
  output logic [PPN_W-1:0] victim,
  output logic             owner_valid,
  output logic [VPN_W-1:0] owner_vpn
);

  localparam int NF = 1 << PPN_W;

  logic [NF-1:0]    own_v;
  logic [VPN_W-1:0] own_vpn [NF];
  logic [PPN_W-1:0] hand;

  always_ff @(posedge clk) begin
    if (reset) begin
      hand  <= '0;
      own_v <= '0;
      for (int i = 0; i < NF; i++)
        own_vpn[i] <= '0;
    end else begin
      if (claim) begin
        own_v[hand]   <= 1'b1;
        own_vpn[hand] <= claim_vpn;
      end
      if (advance)
        hand <= hand + 1'b1;
    end
  end

  assign victim      = hand;
  assign owner_valid = own_v[hand];
  assign owner_vpn   = own_vpn[hand];

endmodule

// File: rtl/page_table_responder.sv
// Page-table responder: serves TLB refills, merges writebacks,
// and fills faults by clock-hand frame replacement.
module page_table_responder
  import page_table_responder_pkg::*;
#(
  parameter int VPN_W   = VPN_W_DEF,
  parameter int PPN_W   = PPN_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             req_ready,
  input  logic             wb_valid,
  input  logic [VPN_W-1:0] wb_vpn,
  input  logic [1:0]       wb_dirty_ref,
  output logic             rsp_valid,
  output logic [31:0]      rsp_pte,
  output logic             rsp_fault,
  output logic             evict_valid,
  output logic [VPN_W-1:0] evict_vpn,
  output logic             evict_dirty
);

  localparam int NP    = 1 << VPN_W;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t state, nxt;

  logic [31:0]      pte [NP];
  logic [VPN_W-1:0] vpn_q;
  logic [VPN_W-1:0] wb_vpn_q;
  logic [1:0]       wb_dr_q;
  logic [CNT_W-1:0] cnt;

  logic             claim;
  logic             advance;
  logic [PPN_W-1:0] victim;
  logic             owner_valid;
  logic [VPN_W-1:0] owner_vpn;

  logic [31:0] pte_cur;
  logic        hit;
  logic        last;

  assign pte_cur   = pte[vpn_q];
  assign hit       = pte_valid(pte_cur);
  assign last      = (cnt == CNT_W'(MEM_LAT - 1));
  assign req_ready = (state == IDLE);

  page_table_responder_frame_allocator #(
    .VPN_W(VPN_W),
    .PPN_W(PPN_W)
  ) u_alloc (
    .clk        (clk),
    .reset      (reset),
    .claim      (claim),
    .claim_vpn  (vpn_q),
    .advance    (advance),
    .victim     (victim),
    .owner_valid(owner_valid),
    .owner_vpn  (owner_vpn)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    claim   = 1'b0;
    advance = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb_valid)
          nxt = WB;
        else if (req_valid)
          nxt = LOOKUP;
      end
      WB:     nxt = IDLE;
      LOOKUP: begin
        if (last)
          nxt = hit ? RESP : EVICT;
      end
      EVICT:  nxt = FILL;
      FILL: begin
        nxt     = RESP;
        claim   = 1'b1;
        advance = 1'b1;
      end
      RESP:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NP; i++)
        pte[i] <= '0;
      vpn_q       <= '0;
      wb_vpn_q    <= '0;
      wb_dr_q     <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_pte     <= '0;
      rsp_fault   <= 1'b0;
      evict_valid <= 1'b0;
      evict_vpn   <= '0;
      evict_dirty <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_fault   <= 1'b0;
      evict_valid <= 1'b0;
      evict_dirty <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wb_valid) begin
            wb_vpn_q <= wb_vpn;
            wb_dr_q  <= wb_dirty_ref;
          end else if (req_valid) begin
            vpn_q <= req_vpn;
            cnt   <= '0;
          end
        end
        WB: begin
          // OR-merge only; a writeback never clears status bits
          if (pte_valid(pte[wb_vpn_q])) begin
            pte[wb_vpn_q][PTE_D] <= pte[wb_vpn_q][PTE_D] | wb_dr_q[1];
            pte[wb_vpn_q][PTE_R] <= pte[wb_vpn_q][PTE_R] | wb_dr_q[0];
          end
        end
        LOOKUP: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            if (hit) begin
              rsp_valid <= 1'b1;
              rsp_pte   <= pte_cur;
            end else if (owner_valid) begin
              // pulse lands in the EVICT cycle
              evict_valid <= 1'b1;
              evict_vpn   <= owner_vpn;
              evict_dirty <= pte_dirty(pte[owner_vpn]);
            end
          end
        end
        EVICT: begin
          if (owner_valid) begin
            pte[owner_vpn][PTE_V] <= 1'b0;
            pte[owner_vpn][PTE_D] <= 1'b0;
            pte[owner_vpn][PTE_R] <= 1'b0;
          end
        end
        FILL: begin
          pte[vpn_q] <= pte_make(1'b1, 1'b0, 1'b0, 16'(victim));
          rsp_valid  <= 1'b1;
          rsp_fault  <= 1'b1;
          rsp_pte    <= pte_make(1'b1, 1'b0, 1'b0, 16'(victim));
        end
        RESP: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_page_table_responder.sv
// Directed bench for page_table_responder with a high-level page table
// model and a per-cycle output checker.
module tb_page_table_responder;

  localparam int VW  = 6;
  localparam int PW  = 2;
  localparam int LAT = 2;
  localparam int NF  = 1 << PW;
  localparam int NP  = 1 << VW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [VW-1:0] req_vpn = '0;
  logic          req_ready;
  logic          wb_valid = 1'b0;
  logic [VW-1:0] wb_vpn = '0;
  logic [1:0]    wb_dirty_ref = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_pte;
  logic          rsp_fault;
  logic          evict_valid;
  logic [VW-1:0] evict_vpn;
  logic          evict_dirty;

  page_table_responder #(
    .VPN_W(VW),
    .PPN_W(PW),
    .MEM_LAT(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_vpn     (req_vpn),
    .req_ready   (req_ready),
    .wb_valid    (wb_valid),
    .wb_vpn      (wb_vpn),
    .wb_dirty_ref(wb_dirty_ref),
    .rsp_valid   (rsp_valid),
    .rsp_pte     (rsp_pte),
    .rsp_fault   (rsp_fault),
    .evict_valid (evict_valid),
    .evict_vpn   (evict_vpn),
    .evict_dirty (evict_dirty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // page table model
  bit pv [NP];
  bit pd [NP];
  bit pr [NP];
  int pp [NP];
  bit ov [NF];
  int ovpn [NF];
  int hand;

  // expectations
  int          exp_rsp_cyc = -1;
  int          exp_ev_cyc = -1;
  logic [31:0] exp_pte;
  bit          exp_fault;
  int          exp_ev_vpn;
  bit          exp_ev_dirty;
  int          busy_lo = -1;
  int          busy_hi = -1;

  // observations
  int          last_T;
  int          last_rsp_cyc;
  logic [31:0] last_pte;
  bit          last_fault;
  int          ev_count = 0;
  int          last_ev_vpn;
  bit          last_ev_dirty;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] mk(bit v, bit d, bit r, int ppn);
    logic [31:0] x;
    x = 32'(ppn);
    x = x + (v ? 32'h8000_0000 : 32'h0);
    x = x + (d ? 32'h4000_0000 : 32'h0);
    x = x + (r ? 32'h2000_0000 : 32'h0);
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      pv[i] = 0; pd[i] = 0; pr[i] = 0; pp[i] = 0;
    end
    for (int i = 0; i < NF; i++) begin
      ov[i] = 0; ovpn[i] = 0;
    end
    hand = 0;
  endtask

  task automatic model_req(input int vpn, input int t);
    int v;
    if (pv[vpn]) begin
      exp_pte     = mk(1, pd[vpn], pr[vpn], pp[vpn]);
      exp_fault   = 0;
      exp_ev_cyc  = -1;
      exp_rsp_cyc = t + LAT + 1;
    end else begin
      v = hand;
      if (ov[v]) begin
        exp_ev_cyc   = t + LAT + 1;
        exp_ev_vpn   = ovpn[v];
        exp_ev_dirty = pd[ovpn[v]];
        pv[ovpn[v]] = 0; pd[ovpn[v]] = 0; pr[ovpn[v]] = 0;
      end else begin
        exp_ev_cyc = -1;
      end
      pv[vpn] = 1; pd[vpn] = 0; pr[vpn] = 0; pp[vpn] = v;
      ov[v] = 1; ovpn[v] = vpn;
      hand = (hand + 1) % NF;
      exp_pte     = mk(1, 0, 0, v);
      exp_fault   = 1;
      exp_rsp_cyc = t + LAT + 3;
    end
    busy_lo = t + 1;
    busy_hi = exp_rsp_cyc;
  endtask

  task automatic model_wb(input int vpn, input logic [1:0] dr);
    if (pv[vpn]) begin
      pd[vpn] = pd[vpn] | dr[1];
      pr[vpn] = pr[vpn] | dr[0];
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 cyc=%0d", cyc);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((cyc <= exp_rsp_cyc || cyc <= busy_hi) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic issue_req(input int vpn);
    wait_ready();
    last_T = cyc;
    model_req(vpn, cyc);
    req_valid = 1'b1;
    req_vpn   = VW'(vpn);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input int vpn);
    issue_req(vpn);
    wait_done();
  endtask

  task automatic do_wb(input int vpn, input logic [1:0] dr);
    wait_ready();
    last_T = cyc;
    model_wb(vpn, dr);
    exp_rsp_cyc = -1;
    exp_ev_cyc  = -1;
    busy_lo = cyc + 1;
    busy_hi = cyc + 1;
    wb_valid     = 1'b1;
    wb_vpn       = VW'(vpn);
    wb_dirty_ref = dr;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  // wb and req raised together; req is held until accepted
  task automatic do_wb_req(input int wv, input logic [1:0] dr, input int rv,
                           output int twb);
    wait_ready();
    twb = cyc;
    model_wb(wv, dr);
    exp_rsp_cyc = -1;
    exp_ev_cyc  = -1;
    busy_lo = cyc + 1;
    busy_hi = cyc + 1;
    wb_valid     = 1'b1;
    wb_vpn       = VW'(wv);
    wb_dirty_ref = dr;
    req_valid    = 1'b1;
    req_vpn      = VW'(rv);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(posedge clk); #1;
    last_T = cyc;
    model_req(rv, cyc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_ready", 32'(req_ready),
          32'(!(cyc >= busy_lo && cyc <= busy_hi)));
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc == exp_rsp_cyc));
      if (rsp_valid && cyc == exp_rsp_cyc) begin
        chk("rsp_pte", rsp_pte, exp_pte);
        chk("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
        last_pte     = rsp_pte;
        last_fault   = rsp_fault;
        last_rsp_cyc = cyc;
      end
      chk("evict_valid", 32'(evict_valid), 32'(cyc == exp_ev_cyc));
      if (evict_valid && cyc == exp_ev_cyc) begin
        chk("evict_vpn", 32'(evict_vpn), 32'(exp_ev_vpn));
        chk("evict_dirty", 32'(evict_dirty), 32'(exp_ev_dirty));
        ev_count++;
        last_ev_vpn   = int'(evict_vpn);
        last_ev_dirty = evict_dirty;
      end
    end
  end

  initial begin
    int twb;
    int ev_before;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_rsp_pte", rsp_pte, 32'h0);
    chk("rst_evict_valid", 32'(evict_valid), 32'd0);
    chk("rst_evict_vpn", 32'(evict_vpn), 32'd0);
    chk("rst_evict_dirty", 32'(evict_dirty), 32'd0);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // first fault fills ppn 0, no eviction
    do_req(5);
    chk("t1_pte", last_pte, 32'h8000_0000);
    chk("t1_fault", 32'(last_fault), 32'd1);
    chk("t1_lat", 32'(last_rsp_cyc - last_T), 32'd5);
    chk("t1_no_evict", 32'(ev_count), 32'd0);

    // hit
    do_req(5);
    chk("t2_pte", last_pte, 32'h8000_0000);
    chk("t2_fault", 32'(last_fault), 32'd0);
    chk("t2_lat", 32'(last_rsp_cyc - last_T), 32'd3);

    // writeback merge then hit
    do_wb(5, 2'b11);
    twb = last_T;
    do_req(5);
    chk("t3_wb_gap", 32'(last_T - twb), 32'd2);
    chk("t3_pte", last_pte, 32'hE000_0000);
    chk("t3_fault", 32'(last_fault), 32'd0);

    // fill remaining free frames in hand order
    do_req(6);
    chk("t4_pte6", last_pte, 32'h8000_0001);
    do_req(7);
    chk("t4_pte7", last_pte, 32'h8000_0002);
    do_req(8);
    chk("t4_pte8", last_pte, 32'h8000_0003);
    chk("t4_no_evict", 32'(ev_count), 32'd0);

    // first eviction: dirty owner of frame 0
    do_req(9);
    chk("t5_ev_cnt", 32'(ev_count), 32'd1);
    chk("t5_ev_vpn", 32'(last_ev_vpn), 32'd5);
    chk("t5_ev_dirty", 32'(last_ev_dirty), 32'd1);
    chk("t5_pte", last_pte, 32'h8000_0000);

    // evicted vpn faults again, evicts clean vpn 6
    do_req(5);
    chk("t6_fault", 32'(last_fault), 32'd1);
    chk("t6_ev_vpn", 32'(last_ev_vpn), 32'd6);
    chk("t6_ev_dirty", 32'(last_ev_dirty), 32'd0);
    chk("t6_pte", last_pte, 32'h8000_0001);

    // writeback to evicted vpn is ignored
    do_wb(6, 2'b11);
    do_req(6);
    chk("t7_fault", 32'(last_fault), 32'd1);
    chk("t7_pte", last_pte, 32'h8000_0002);
    chk("t7_ev_vpn", 32'(last_ev_vpn), 32'd7);

    // simultaneous wb (invalid vpn) and req
    do_wb_req(60, 2'b11, 60, twb);
    chk("t8_gap", 32'(last_T - twb), 32'd2);
    chk("t8_fault", 32'(last_fault), 32'd1);
    chk("t8_pte", last_pte, 32'h8000_0003);
    chk("t8_ev_vpn", 32'(last_ev_vpn), 32'd8);

    // simultaneous wb (valid vpn) and req: wb applied first
    do_wb_req(9, 2'b10, 9, twb);
    chk("t9_gap", 32'(last_T - twb), 32'd2);
    chk("t9_fault", 32'(last_fault), 32'd0);
    chk("t9_pte", last_pte, 32'hC000_0000);

    // reset during lookup aborts with no response
    issue_req(7);
    reset = 1'b1;
    model_reset();
    exp_rsp_cyc = -1;
    exp_ev_cyc  = -1;
    busy_lo = cyc;
    busy_hi = cyc;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    ev_before = ev_count;
    do_req(5);
    chk("t10_fault", 32'(last_fault), 32'd1);
    chk("t10_pte", last_pte, 32'h8000_0000);
    chk("t10_no_evict", 32'(ev_count - ev_before), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/page_table_responder.md
Name: page_table_responder

Overview:
- Memory-side responder for the TLB miss/writeback interface.
- Holds the full single-level page table (one PTE per VPN) and serves TLB refill lookups.
- Merges dirty/ref writebacks from the TLB into the PTEs.
- On a page fault, allocates a physical frame by clock-hand replacement, evicting the frame's previous owner.
- Sits between the TLB and the (modelled) backing store.

Parameters:
- VPN_W, 6, virtual page number width (table depth = 2^VPN_W).
- PPN_W, 2, physical page number width (frame count = 2^PPN_W).
- MEM_LAT, 2, cycles spent in LOOKUP modelling page-table memory latency (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  TLB refill request valid.
- req_vpn  in  VPN_W  VPN to look up.
- req_ready  out  1  responder can accept a request or writeback (high only in IDLE).
- wb_valid  in  1  TLB writeback of evicted entry valid.
- wb_vpn  in  VPN_W  VPN of evicted TLB entry.
- wb_dirty_ref  in  2  {dirty, ref} bits to merge.
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_pte  out  32  PTE: [31] valid, [30] dirty, [29] ref, [PPN_W-1:0] ppn, others 0.
- rsp_fault  out  1  with rsp_valid: the lookup faulted and was just filled.
- evict_valid  out  1  one-cycle pulse: a frame owner was evicted.
- evict_vpn  out  VPN_W  evicted VPN.
- evict_dirty  out  1  evicted PTE was dirty (backing-store writeback needed).

Behaviour:
- Reset (synchronous, active-high):
  - All PTEs 0 (invalid); all frame-owner entries invalid; clock hand = 0; FSM = IDLE.
  - rsp_valid, rsp_fault, evict_valid, evict_dirty = 0; rsp_pte = 0; evict_vpn = 0.
  - req_ready = 1 from the first cycle after reset.
  - Reset mid-operation aborts the transaction with no response.
- States: IDLE, WB, LOOKUP, EVICT, FILL, RESP.
- IDLE:
  - If wb_valid, it takes priority over req_valid in the same cycle. Latch the writeback, go to WB; req is not accepted and must be held.
  - Else if req_valid, latch req_vpn, clear the latency counter, go to LOOKUP.
- WB (1 cycle):
  - If PTE[wb_vpn].valid: PTE[30] |= dirty and PTE[29] |= ref (OR-merge, never clear).
  - If the PTE is invalid, the writeback is ignored.
  - Go to IDLE. No response is produced.
- LOOKUP:
  - Stays MEM_LAT cycles.
  - If the PTE is valid, go to RESP with rsp_fault=0 and the PTE unchanged.
  - Otherwise go to EVICT.
- EVICT (1 cycle):
  - victim = hand.
  - If owner[victim] is valid: clear PTE[owner].valid/dirty/ref and pulse evict_valid with evict_vpn=owner and evict_dirty=old dirty.
  - Otherwise no pulse.
- FILL (1 cycle):
  - PTE[vpn] = valid=1, dirty=0, ref=0, ppn=victim.
  - owner[victim] = vpn.
  - hand = hand+1, wrapping modulo 2^PPN_W.
  - Set rsp_fault=1 and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_pte = current PTE[vpn].
  - Go to IDLE.
- Latency, measured from the accept edge T:
  - Hit: rsp_valid high in cycle T+MEM_LAT+1.
  - Fault: rsp_valid high in cycle T+MEM_LAT+3.
  - Writeback: next request accepted at T+2 at the earliest.
- Boundary cases:
  - Free frames are used in hand order 0,1,2,3 before any eviction occurs.
  - A request for the VPN whose mapping was just evicted faults again.
  - A writeback for an evicted VPN is ignored.
  - Inputs are ignored while req_ready=0.
  - Outputs are registered.

Decomposition:
- Shared package contents:
  - PTE bit positions: PTE_V=31, PTE_D=30, PTE_R=29.
  - Constants for the VPN_W/PPN_W defaults.
  - FSM state enum.
  - PTE construct/extract functions, shared with the TLB.
- Natural sub-module: frame_allocator. It holds the owner table and clock hand, and provides victim, owner-valid, owner-VPN, claim and advance.

Test Plan:
- Reset, then req vpn=5 -> fault path:
  - No evict_valid.
  - rsp_valid at T+5 (MEM_LAT=2), rsp_fault=1, rsp_pte=0x80000000.
- Repeat req vpn=5 -> hit: rsp_valid at T+3, rsp_fault=0, rsp_pte=0x80000000.
- wb vpn=5 dirty_ref=2'b11, then req vpn=5 -> rsp_pte=0xE0000000, rsp_fault=0.
- Faults on vpn 6, 7, 8 fill ppn 1, 2, 3. Then req vpn=9:
  - evict_valid with evict_vpn=5 and evict_dirty=1.
  - rsp_pte=0x80000000 (ppn 0).
  - A following req vpn=5 faults and evicts vpn 6 with evict_dirty=0.
- wb_valid and req_valid in the same IDLE cycle -> wb applied first; req_ready=0 for 1 cycle; req accepted next IDLE cycle. wb vpn=60 (invalid) -> no PTE change.
- Assert reset during LOOKUP -> no rsp_valid; a following req vpn=5 faults with ppn 0.
